// File: rtl/rfe_enroll_ctrl.sv
// Enrollment controller: triggers the helper-data generator, retries on timeout,
// then streams the captured helper data out as 32-bit words with a valid/ready handshake.
module rfe_enroll_ctrl #(
    parameter int unsigned BLOCKS    = 22,
    parameter int unsigned N         = 32,
    parameter int unsigned TIMEOUT   = 255,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  gen_enable,
    input  logic                  gen_complete,
    input  logic [BLOCKS*N-1:0]   gen_helper,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int unsigned WORDS = BLOCKS * N / 32;
    localparam int unsigned IDXW  = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int unsigned CW    = $clog2(TIMEOUT);
    localparam int unsigned RW    = $clog2(MAX_RETRY + 2);

    typedef enum logic [2:0] {
        StIdle,
        StTrig,
        StWait,
        StStream,
        StDone
    } state_e;

    state_e                  state_q;
    logic [WORDS-1:0][31:0]  helper_q;
    logic [IDXW-1:0]         idx_q;
    logic [IDXW-1:0]         idx_inc;
    logic [CW-1:0]           cnt_q;
    logic [RW-1:0]           retry_q;

    assign idx_inc = idx_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            helper_q   <= '0;
            idx_q      <= '0;
            cnt_q      <= '0;
            retry_q    <= '0;
            gen_enable <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            gen_enable <= 1'b0;
            done       <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q    <= StTrig;
                        gen_enable <= 1'b1;
                        busy       <= 1'b1;
                        error      <= 1'b0;
                        retry_q    <= '0;
                    end
                end
                StTrig: begin
                    state_q <= StWait;
                    cnt_q   <= '0;
                end
                StWait: begin
                    // Completion takes priority over an expiry in the same cycle.
                    if (gen_complete) begin
                        state_q   <= StStream;
                        helper_q  <= gen_helper;
                        idx_q     <= '0;
                        out_valid <= 1'b1;
                        out_data  <= gen_helper[31:0];
                        out_last  <= (WORDS == 1);
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        if (retry_q < RW'(MAX_RETRY)) begin
                            retry_q    <= retry_q + 1'b1;
                            state_q    <= StTrig;
                            gen_enable <= 1'b1;
                        end else begin
                            state_q <= StIdle;
                            error   <= 1'b1;
                            busy    <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StStream: begin
                    if (out_ready) begin
                        if (out_last) begin
                            state_q   <= StDone;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            out_data  <= '0;
                            done      <= 1'b1;
                        end else begin
                            idx_q    <= idx_inc;
                            out_data <= helper_q[idx_inc];
                            out_last <= (idx_inc == IDXW'(WORDS - 1));
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rfe_enroll_ctrl.sv
// Bench for rfe_enroll_ctrl: a default instance for streaming/handshake runs and a
// TIMEOUT=8, two-word instance for the cycle table and timeout/retry sequences.
module tb_rfe_enroll_ctrl;

    localparam int unsigned AW = 22;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Instance A: default parameters.
    logic              start_a = 1'b0, gen_complete_a = 1'b0, out_ready_a = 1'b0;
    logic [AW*32-1:0]  gen_helper_a = '0;
    logic              gen_enable_a, out_valid_a, out_last_a, busy_a, done_a, error_a;
    logic [31:0]       out_data_a;

    // Instance B: TIMEOUT=8, BLOCKS=4, N=16 -> two words.
    logic              start_b = 1'b0, gen_complete_b = 1'b0, out_ready_b = 1'b0;
    logic [63:0]       gen_helper_b = '0;
    logic              gen_enable_b, out_valid_b, out_last_b, busy_b, done_b, error_b;
    logic [31:0]       out_data_b;

    rfe_enroll_ctrl dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .gen_enable(gen_enable_a),
        .gen_complete(gen_complete_a), .gen_helper(gen_helper_a), .out_valid(out_valid_a),
        .out_ready(out_ready_a), .out_data(out_data_a), .out_last(out_last_a),
        .busy(busy_a), .done(done_a), .error(error_a)
    );

    rfe_enroll_ctrl #(.BLOCKS(4), .N(16), .TIMEOUT(8), .MAX_RETRY(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .gen_enable(gen_enable_b),
        .gen_complete(gen_complete_b), .gen_helper(gen_helper_b), .out_valid(out_valid_b),
        .out_ready(out_ready_b), .out_data(out_data_b), .out_last(out_last_b),
        .busy(busy_b), .done(done_b), .error(error_b)
    );

    int checks = 0;
    int failures = 0;
    logic [31:0] words_a [AW];

    typedef struct {
        logic        start, gc, rdy;
        logic        e_gen, e_valid, e_last, e_busy, e_done, e_err;
        logic [31:0] e_data;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%h required=0x%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [AW*32-1:0] pack_a();
        logic [AW*32-1:0] v;
        v = '0;
        for (int i = 0; i < AW; i++) v[i*32 +: 32] = words_a[i];
        return v;
    endfunction

    task automatic randomize_words();
        for (int i = 0; i < AW; i++) words_a[i] = $urandom;
    endtask

    // One enrollment on instance A; gen_complete arrives d cycles after the gen_enable cycle.
    // mode: 0 ready always, 1 ready toggling, 2 ready random. Reference: words_a in order.
    task automatic run_a(input int d, input int mode, input bit hold, input bit noise,
                         input int stop_at);
        int gens, k, bubbles, guard, early_valid, early_done;
        bit tog, rdy, stalled;
        logic [31:0] held;
        logic [AW*32-1:0] good;
        good = pack_a();
        gens = 0; k = 0; bubbles = 0; guard = 0; early_valid = 0; early_done = 0;
        tog = 1'b0; stalled = 1'b0; held = '0;
        if (noise) begin
            gen_helper_a = ~good;
            gen_complete_a = 1'b1;
            tick();
            gen_complete_a = 1'b0;
            chk("idle_gc_valid", out_valid_a, 0);
            chk("idle_gc_gen_en", gen_enable_a, 0);
            chk("idle_gc_busy", busy_a, 0);
        end
        start_a = 1'b1;
        tick();
        if (!hold) start_a = 1'b0;
        chk("trig_gen_en", gen_enable_a, 1);
        chk("trig_busy", busy_a, 1);
        chk("start_error_clear", error_a, 0);
        gens = 1;
        for (int c = 0; c < d; c++) begin
            tick();
            if (gen_enable_a) gens++;
            if (out_valid_a) early_valid++;
        end
        gen_helper_a = good;
        gen_complete_a = 1'b1;
        tick();
        gen_complete_a = 1'b0;
        if (noise) gen_helper_a = ~good;
        chk("stream_entry_valid", out_valid_a, 1);
        while (k < stop_at && guard < 4000) begin
            rdy = (mode == 0) ? 1'b1 : (mode == 1) ? tog : ($urandom_range(0, 3) != 0);
            tog = ~tog;
            out_ready_a = rdy;
            gen_complete_a = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            if (!out_valid_a) bubbles++;
            if (done_a) early_done++;
            if (out_valid_a && rdy) begin
                chk($sformatf("word%0d_data", k), out_data_a, words_a[k]);
                chk($sformatf("word%0d_last", k), out_last_a, (k == AW - 1));
                k++;
            end else if (out_valid_a) begin
                held = out_data_a;
                stalled = 1'b1;
            end
            if (k == AW) start_a = 1'b0;
            tick();
            guard++;
            if (gen_enable_a) gens++;
            if (stalled) begin
                chk("stall_hold", out_data_a, held);
                stalled = 1'b0;
            end
        end
        out_ready_a = 1'b0;
        gen_complete_a = 1'b0;
        gen_helper_a = good;
        chk("words_sent", k, stop_at);
        chk("no_bubble", bubbles, 0);
        chk("no_valid_in_wait", early_valid, 0);
        chk("no_early_done", early_done, 0);
        chk("single_gen_pulse", gens, 1);
        if (stop_at == AW) begin
            chk("done_pulse", done_a, 1);
            chk("done_valid", out_valid_a, 0);
            chk("done_busy", busy_a, 1);
            chk("done_error", error_a, 0);
            tick();
            chk("post_done", done_a, 0);
            chk("post_done_busy", busy_a, 0);
            chk("post_done_gen_en", gen_enable_a, 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs [11];
        int gens, err_at, done_seen, back_to_back;
        int pulse_t [4];
        bit prev_gen;

        // Two-word run on instance B; word0 = 0x33334444, word1 = 0x11112222.
        //          start gc  rdy  gen valid last busy done err data
        vecs[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0};
        vecs[1]  = '{1, 0, 0, 1, 0, 0, 1, 0, 0, 32'h0};
        vecs[2]  = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h0};
        vecs[3]  = '{0, 1, 0, 0, 1, 0, 1, 0, 0, 32'h3333_4444};
        vecs[4]  = '{0, 0, 0, 0, 1, 0, 1, 0, 0, 32'h3333_4444};
        vecs[5]  = '{0, 0, 1, 0, 1, 1, 1, 0, 0, 32'h1111_2222};
        vecs[6]  = '{0, 0, 0, 0, 1, 1, 1, 0, 0, 32'h1111_2222};
        vecs[7]  = '{0, 0, 1, 0, 0, 0, 1, 1, 0, 32'h0};
        vecs[8]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0};
        vecs[9]  = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0};
        vecs[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rst_gen_en", gen_enable_a, 0);
        chk("rst_valid", out_valid_a, 0);
        chk("rst_data", out_data_a, 0);
        chk("rst_last", out_last_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_error", error_a, 0);

        gen_helper_b = 64'h1111_2222_3333_4444;
        for (int i = 0; i < 11; i++) begin
            start_b = vecs[i].start;
            gen_complete_b = vecs[i].gc;
            out_ready_b = vecs[i].rdy;
            tick();
            chk($sformatf("vec%0d_gen", i), gen_enable_b, vecs[i].e_gen);
            chk($sformatf("vec%0d_valid", i), out_valid_b, vecs[i].e_valid);
            chk($sformatf("vec%0d_last", i), out_last_b, vecs[i].e_last);
            chk($sformatf("vec%0d_busy", i), busy_b, vecs[i].e_busy);
            chk($sformatf("vec%0d_done", i), done_b, vecs[i].e_done);
            chk($sformatf("vec%0d_err", i), error_b, vecs[i].e_err);
            if (vecs[i].e_valid) chk($sformatf("vec%0d_data", i), out_data_b, vecs[i].e_data);
        end
        start_b = 1'b0; gen_complete_b = 1'b0; out_ready_b = 1'b0;

        // Full stream with ready high, then ready toggling, on the same marked words.
        randomize_words();
        words_a[0] = 32'hA5A5_0001;
        words_a[AW-1] = 32'h5A5A_0022;
        run_a(10, 0, 1'b0, 1'b0, AW);
        run_a(4, 1, 1'b0, 1'b0, AW);
        // start held high and spurious gen_complete outside WAIT.
        run_a(6, 2, 1'b1, 1'b1, AW);
        for (int r = 0; r < 4; r++) begin
            randomize_words();
            run_a(int'($urandom_range(1, 40)), 2, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), AW);
        end

        // Asynchronous reset at word 5, then a fresh enrollment from word 0.
        randomize_words();
        run_a(3, 0, 1'b0, 1'b0, 5);
        chk("pre_reset_valid", out_valid_a, 1);
        chk("pre_reset_word5", out_data_a, words_a[5]);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", out_valid_a, 0);
        chk("async_rst_data", out_data_a, 0);
        chk("async_rst_busy", busy_a, 0);
        chk("async_rst_last", out_last_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_rst_valid", out_valid_a, 0);
        chk("post_rst_gen_en", gen_enable_a, 0);
        randomize_words();
        run_a(5, 1, 1'b0, 1'b0, AW);

        // Instance B: generator never completes -> 4 attempts 9 cycles apart, then error.
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        gens = 0; err_at = -1; done_seen = 0; back_to_back = 0; prev_gen = 1'b0;
        for (int t = 0; t < 60; t++) begin
            if (gen_enable_b) begin
                if (gens < 4) pulse_t[gens] = t;
                gens++;
                if (prev_gen) back_to_back++;
            end
            prev_gen = gen_enable_b;
            if (error_b && err_at < 0) err_at = t;
            if (done_b) done_seen++;
            tick();
        end
        chk("timeout_gen_pulses", gens, 4);
        chk("timeout_pulse_width", back_to_back, 0);
        if (gens == 4) begin
            for (int i = 1; i < 4; i++)
                chk($sformatf("timeout_spacing%0d", i), pulse_t[i] - pulse_t[i-1], 9);
        end
        chk("timeout_error_cycle", err_at, 36);
        chk("timeout_error_sticky", error_b, 1);
        chk("timeout_busy", busy_b, 0);
        chk("timeout_no_done", done_seen, 0);

        // Instance B: first attempt silent, completion on the second at counter 7.
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        chk("retry_error_cleared", error_b, 0);
        chk("retry_first_gen", gen_enable_b, 1);
        repeat (9) tick();
        chk("retry_second_gen", gen_enable_b, 1);
        gens = 0;
        repeat (8) begin
            tick();
            if (gen_enable_b) gens++;
        end
        chk("retry_no_extra_gen", gens, 0);
        chk("retry_still_waiting", out_valid_b, 0);
        gen_helper_b = 64'hDEAD_BEEF_0BAD_F00D;
        gen_complete_b = 1'b1;
        tick();
        gen_complete_b = 1'b0;
        chk("retry_stream_valid", out_valid_b, 1);
        chk("retry_word0", out_data_b, 32'h0BAD_F00D);
        chk("retry_error", error_b, 0);
        chk("retry_gen_after", gen_enable_b, 0);
        out_ready_b = 1'b1;
        tick();
        chk("retry_word1", out_data_b, 32'hDEAD_BEEF);
        chk("retry_last", out_last_b, 1);
        tick();
        out_ready_b = 1'b0;
        chk("retry_done", done_b, 1);
        tick();
        chk("retry_idle_busy", busy_b, 0);
        chk("retry_final_error", error_b, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
